vcop_xif_issue_tracker: RTL and testbench
=========================================

VCOP_XIF_ISSUE_TRACKER -- requirements
Module: vcop_xif_issue_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of accepted-instruction queue entries (power of 2, 2..8).
REQ-002 SHALL have port clk_i  input  1  rising-edge clock.
REQ-003 SHALL have port rst_ni  input  1  reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port issue_valid_i  input  1  core offers an instruction.
REQ-005 SHALL have port issue_ready_o  output  1  tracker can take an issue handshake.
REQ-006 SHALL have port issue_req_i  input  x_issue_req_t  instr, mode, id, rs[1:0], rs_valid.
REQ-007 SHALL have port issue_resp_o  output  x_issue_resp_t  accept/writeback decision.
REQ-008 SHALL have port commit_valid_i  input  1  commit/kill strobe.
REQ-009 SHALL have port commit_i  input  x_commit_t  id and commit_kill.
REQ-010 SHALL have port ex_valid_o / ex_ready_i  output/input  1/1  dispatch handshake to vector execution.
REQ-011 SHALL have port ex_instr_o, ex_rs0_o, ex_rs1_o  output  32 each  dispatched instruction and operands.
REQ-012 SHALL have port done_valid_i, done_data_i  input  1, 32  execution completion and result data.
REQ-013 SHALL have port result_valid_o / result_ready_i  output/input  1/1  result handshake to core.
REQ-014 SHALL have port result_o  output  x_result_t  id, data, rd, we; all other fields 0.

Function
REQ-015 SHALL decode combinationally: accept = (instr[6:0]==7'h57) and rs_valid==2'b11; writeback = accept and instr[14:12]==3'b111; dualwrite, dualread, loadstore, ecswrite, exc SHALL be 0.
REQ-016 SHALL drive issue_ready_o = not full; issue handshake = issue_valid_i and issue_ready_o; issue_resp_o is valid only in handshake cycles.
REQ-017 SHALL push {id, instr, rs0, rs1, writeback, rd=instr[11:7]} into the queue on handshake with accept=1; rejected instructions SHALL NOT be stored.
REQ-018 SHALL, on commit_valid_i, mark the stored entry whose id matches as committed (commit_kill=0) or killed (commit_kill=1); a commit matching the id being pushed in the same cycle SHALL apply to the new entry; commits matching no entry SHALL be ignored.
REQ-019 SHALL run FSM IDLE, EXEC, WAIT, RESP on the queue head:
- IDLE: head killed -> pop, stay IDLE (1 cycle per kill); head committed -> EXEC.
- EXEC: ex_valid_o=1 with head fields; on ex_ready_i -> WAIT.
- WAIT: on done_valid_i, register result (id, data=done_data_i, rd, we=writeback) -> RESP.
- RESP: result_valid_o=1, result_o held stable; on result_ready_i pop head -> IDLE.
REQ-020 SHALL give latency: head committed in cycle n -> ex_valid_o in n+1; done_valid_i in cycle m -> result_valid_o in m+1.
REQ-021 SHALL produce exactly one result per committed accepted instruction, in issue order; killed entries SHALL produce no dispatch and no result.
REQ-022 SHALL ignore done_valid_i outside WAIT.
REQ-023 SHALL allow push and pop in the same cycle; occupancy unchanged; pointers wrap modulo DEPTH.
REQ-024 SHALL not bypass: when full, issue_ready_o=0 even if a pop occurs that cycle.

Reset
REQ-025 SHALL, while rst_ni=0, empty the queue, clear all flags, FSM=IDLE; outputs: issue_ready_o=1, ex_valid_o=0, result_valid_o=0, ex_*/result_o=0.
REQ-026 SHALL, on reset mid-operation, discard all in-flight entries and any pending result without emitting it.

Verification
REQ-027 SHALL verify: issue instr=32'h0020F0D7 (funct3=111), id=3, rs_valid=11 -> accept=1, writeback=1; commit id=3 -> ex_valid_o next cycle; done_data_i=5 -> result id=3, rd=1, we=1, data=5.
REQ-028 SHALL verify: issue instr=32'h00000033 -> accept=0, queue unchanged, no result ever.
REQ-029 SHALL verify: issue ids 1,2; kill id 1, commit id 2 -> only id 2 dispatched and resulted.
REQ-030 SHALL verify: 4 accepted issues without commit -> issue_ready_o=0; commit+complete head -> issue_ready_o=1 the cycle after pop.
REQ-031 SHALL verify: issue id=5 with commit id=5 same cycle -> entry committed, dispatched next cycle.
REQ-032 SHALL verify: result_ready_i held 0 for 3 cycles -> result_o stable; rst_ni low in WAIT -> all outputs at reset values, no result emitted.

Source files
------------

// File: rtl/vcop_xif_issue_tracker.sv
// rtl/vcop_xif_issue_tracker.sv - in-order issue/commit/result tracker for a vector coprocessor
package vcop_xif_pkg;
  localparam int ID_W = 4;

  typedef struct packed {
    logic [31:0]      instr;
    logic [1:0]       mode;
    logic [ID_W-1:0]  id;
    logic [1:0][31:0] rs;
    logic [1:0]       rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic ecswrite;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic [4:0]      rd;
    logic            we;
    logic [2:0]      ecswe;
    logic [5:0]      ecsdata;
    logic            exc;
    logic [5:0]      exccode;
    logic            err;
    logic            dbg;
  } x_result_t;
endpackage

module vcop_xif_issue_tracker
  import vcop_xif_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          issue_valid_i,
  output logic          issue_ready_o,
  input  x_issue_req_t  issue_req_i,
  output x_issue_resp_t issue_resp_o,
  input  logic          commit_valid_i,
  input  x_commit_t     commit_i,
  output logic          ex_valid_o,
  input  logic          ex_ready_i,
  output logic [31:0]   ex_instr_o,
  output logic [31:0]   ex_rs0_o,
  output logic [31:0]   ex_rs1_o,
  input  logic          done_valid_i,
  input  logic [31:0]   done_data_i,
  output logic          result_valid_o,
  input  logic          result_ready_i,
  output x_result_t     result_o
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [ID_W-1:0] q_id    [DEPTH];
  logic [31:0]     q_instr [DEPTH];
  logic [31:0]     q_rs0   [DEPTH];
  logic [31:0]     q_rs1   [DEPTH];
  logic [4:0]      q_rd    [DEPTH];
  logic [DEPTH-1:0] q_wb, q_vld, q_cmt, q_kill;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  x_result_t       res_q;

  logic dec_accept, dec_wb, hs, push, pop, full;
  logic commit_hit_push, head_vld, head_cmt_now;
  logic unused_mode;

  assign unused_mode = ^issue_req_i.mode;

  assign dec_accept = (issue_req_i.instr[6:0] == 7'h57) && (issue_req_i.rs_valid == 2'b11);
  assign dec_wb     = dec_accept && (issue_req_i.instr[14:12] == 3'b111);
  assign full          = (count == (PW+1)'(DEPTH));
  assign issue_ready_o = !full;
  assign hs            = issue_valid_i && issue_ready_o;
  assign push          = hs && dec_accept;

  assign commit_hit_push = commit_valid_i && push && (commit_i.id == issue_req_i.id);
  assign head_vld        = q_vld[rd_ptr];
  // a commit strobe for the head counts immediately so dispatch follows the next edge
  assign head_cmt_now    = q_cmt[rd_ptr] ||
                           (commit_valid_i && !commit_i.commit_kill && (q_id[rd_ptr] == commit_i.id));

  // issue response is only meaningful during a handshake
  always_comb begin
    issue_resp_o           = '0;
    issue_resp_o.accept    = hs && dec_accept;
    issue_resp_o.writeback = hs && dec_wb;
  end

  // queue payload; only the flags need a reset
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_id[wr_ptr]    <= issue_req_i.id;
      q_instr[wr_ptr] <= issue_req_i.instr;
      q_rs0[wr_ptr]   <= issue_req_i.rs[0];
      q_rs1[wr_ptr]   <= issue_req_i.rs[1];
      q_rd[wr_ptr]    <= issue_req_i.instr[11:7];
      q_wb[wr_ptr]    <= dec_wb;
    end
  end

  // queue pointers, occupancy and per-entry commit/kill flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_vld  <= '0;
      q_cmt  <= '0;
      q_kill <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (commit_valid_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q_vld[i] && (q_id[i] == commit_i.id)) begin
            if (commit_i.commit_kill) q_kill[i] <= 1'b1;
            else                      q_cmt[i]  <= 1'b1;
          end
        end
      end
      if (pop) begin
        q_vld[rd_ptr]  <= 1'b0;
        q_cmt[rd_ptr]  <= 1'b0;
        q_kill[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
      end
      if (push) begin
        q_vld[wr_ptr]  <= 1'b1;
        q_cmt[wr_ptr]  <= commit_hit_push && !commit_i.commit_kill;
        q_kill[wr_ptr] <= commit_hit_push && commit_i.commit_kill;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // head FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // head FSM next state; an empty queue lets a same-cycle issue+commit dispatch straight away
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (head_vld) begin
          if (q_kill[rd_ptr])    pop = 1'b1;
          else if (head_cmt_now) state_nxt = EXEC;
        end else if (commit_hit_push && !commit_i.commit_kill) begin
          state_nxt = EXEC;
        end
      end
      EXEC: if (ex_ready_i) state_nxt = WAIT;
      WAIT: if (done_valid_i) state_nxt = RESP;
      RESP: begin
        if (result_ready_i) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // capture the completion so the result stays stable while the core stalls
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_q <= '0;
    end else if ((state == WAIT) && done_valid_i) begin
      res_q.id   <= q_id[rd_ptr];
      res_q.data <= done_data_i;
      res_q.rd   <= q_rd[rd_ptr];
      res_q.we   <= q_wb[rd_ptr];
    end
  end

  assign ex_valid_o     = (state == EXEC);
  assign ex_instr_o     = ex_valid_o ? q_instr[rd_ptr] : '0;
  assign ex_rs0_o       = ex_valid_o ? q_rs0[rd_ptr] : '0;
  assign ex_rs1_o       = ex_valid_o ? q_rs1[rd_ptr] : '0;
  assign result_valid_o = (state == RESP);
  assign result_o       = result_valid_o ? res_q : '0;
endmodule

// File: tb/tb_vcop_xif_issue_tracker.sv
// tb/tb_vcop_xif_issue_tracker.sv - scoreboard bench for vcop_xif_issue_tracker
module tb_vcop_xif_issue_tracker;
  import vcop_xif_pkg::*;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          issue_valid_i;
  logic          issue_ready_o;
  x_issue_req_t  issue_req_i;
  x_issue_resp_t issue_resp_o;
  logic          commit_valid_i;
  x_commit_t     commit_i;
  logic          ex_valid_o;
  logic          ex_ready_i;
  logic [31:0]   ex_instr_o, ex_rs0_o, ex_rs1_o;
  logic          done_valid_i;
  logic [31:0]   done_data_i;
  logic          result_valid_o;
  logic          result_ready_i;
  x_result_t     result_o;

  int total = 0;
  int bad   = 0;
  logic auto_done = 1'b1;

  x_issue_resp_t exp_resp [$];
  logic [95:0]   exp_ex   [$];
  x_result_t     exp_res  [$];
  logic [31:0]   done_q   [$];

  vcop_xif_issue_tracker #(.DEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_req_i(issue_req_i), .issue_resp_o(issue_resp_o),
    .commit_valid_i(commit_valid_i), .commit_i(commit_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_instr_o(ex_instr_o), .ex_rs0_o(ex_rs0_o), .ex_rs1_o(ex_rs1_o),
    .done_valid_i(done_valid_i), .done_data_i(done_data_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] rs0_of(input logic [3:0] id);
    return {28'hA000000, id};
  endfunction

  function automatic logic [31:0] rs1_of(input logic [3:0] id);
    return {28'hB000000, id};
  endfunction

  function automatic x_issue_resp_t mk_resp(input logic acc, input logic wb);
    x_issue_resp_t r;
    r = '0;
    r.accept = acc;
    r.writeback = wb;
    return r;
  endfunction

  function automatic x_result_t mk_res(input logic [3:0] id, input logic [31:0] d,
                                       input logic [4:0] rd, input logic we);
    x_result_t r;
    r = '0;
    r.id = id;
    r.data = d;
    r.rd = rd;
    r.we = we;
    return r;
  endfunction

  task automatic expect_run(input logic [31:0] instr, input logic [3:0] id, input logic [31:0] d,
                            input logic [4:0] rd, input logic we);
    exp_ex.push_back({instr, rs0_of(id), rs1_of(id)});
    exp_res.push_back(mk_res(id, d, rd, we));
    done_q.push_back(d);
  endtask

  task automatic set_req(input logic [31:0] instr, input logic [3:0] id, input logic [1:0] rsv);
    issue_req_i          = '0;
    issue_req_i.instr    = instr;
    issue_req_i.id       = id;
    issue_req_i.rs[0]    = rs0_of(id);
    issue_req_i.rs[1]    = rs1_of(id);
    issue_req_i.rs_valid = rsv;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [3:0] id, input logic [1:0] rsv,
                       input logic acc, input logic wb);
    int n = 0;
    set_req(instr, id, rsv);
    issue_valid_i = 1'b1;
    exp_resp.push_back(mk_resp(acc, wb));
    while (!issue_ready_o && n < 50) begin
      tick;
      n++;
    end
    if (n >= 50) chk("issue_timeout", 1'b0, 1'b1);
    tick;
    issue_valid_i = 1'b0;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid_i       = 1'b1;
    commit_i.id          = id;
    commit_i.commit_kill = kill;
    tick;
    commit_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_ex.size() != 0 || exp_res.size() != 0) && n < 200) begin
      tick;
      n++;
    end
    chk(name, n < 200, 1'b1);
    repeat (3) tick;
  endtask

  // issue response monitor
  always @(negedge clk_i) begin
    if (rst_ni && issue_valid_i && issue_ready_o) begin
      if (exp_resp.size() == 0) chk("resp_unexpected", 1'b1, 1'b0);
      else chk("issue_resp", issue_resp_o, exp_resp.pop_front());
    end
  end

  // dispatch monitor
  always @(negedge clk_i) begin
    if (ex_valid_o && ex_ready_i) begin
      if (exp_ex.size() == 0) chk("ex_unexpected", 1'b1, 1'b0);
      else chk("ex_fields", {ex_instr_o, ex_rs0_o, ex_rs1_o}, exp_ex.pop_front());
    end
  end

  // result monitor
  always @(negedge clk_i) begin
    if (result_valid_o && result_ready_i) begin
      if (exp_res.size() == 0) chk("res_unexpected", 1'b1, 1'b0);
      else chk("result", result_o, exp_res.pop_front());
    end
  end

  // execution unit model: completes each dispatch two cycles later
  initial begin
    done_valid_i = 1'b0;
    done_data_i  = '0;
    forever begin
      @(negedge clk_i);
      if (auto_done && ex_valid_o && ex_ready_i) begin
        tick;
        tick;
        done_valid_i = 1'b1;
        done_data_i  = (done_q.size() != 0) ? done_q.pop_front() : 32'h0;
        tick;
        done_valid_i = 1'b0;
        done_data_i  = '0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_ni = 1'b0;
    issue_valid_i = 1'b0;
    issue_req_i = '0;
    commit_valid_i = 1'b0;
    commit_i = '0;
    ex_ready_i = 1'b1;
    result_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_issue_ready", issue_ready_o, 1'b1);
    chk("rst_ex_valid", ex_valid_o, 1'b0);
    chk("rst_result_valid", result_valid_o, 1'b0);
    chk("rst_ex_instr", ex_instr_o, 32'h0);
    chk("rst_result", result_o, '0);
    tick;
    rst_ni = 1'b1;
    repeat (2) tick;

    // accepted writeback instruction, commit latency, result fields
    issue(32'h0020F0D7, 4'd3, 2'b11, 1'b1, 1'b1);
    expect_run(32'h0020F0D7, 4'd3, 32'd5, 5'd1, 1'b1);
    commit(4'd3, 1'b0);
    chk("ex_latency", ex_valid_o, 1'b1);
    drain("drain_basic");

    // rejected: wrong opcode, and valid opcode with missing operand
    issue(32'h00000033, 4'd4, 2'b11, 1'b0, 1'b0);
    issue(32'h0020F0D7, 4'd6, 2'b01, 1'b0, 1'b0);
    repeat (10) tick;
    chk("reject_ready", issue_ready_o, 1'b1);

    // kill id 1, commit id 2
    issue(32'h00208057, 4'd1, 2'b11, 1'b1, 1'b0);
    issue(32'h0020F157, 4'd2, 2'b11, 1'b1, 1'b1);
    commit(4'd1, 1'b1);
    expect_run(32'h0020F157, 4'd2, 32'hCAFE0002, 5'd2, 1'b1);
    commit(4'd2, 1'b0);
    drain("drain_kill");

    // fill the queue, no bypass on pop, ready the cycle after pop
    for (int i = 8; i < 12; i++) issue(32'h0020F0D7, 4'(i), 2'b11, 1'b1, 1'b1);
    chk("full_ready", issue_ready_o, 1'b0);
    set_req(32'h00000033, 4'd15, 2'b11);
    issue_valid_i = 1'b1;
    repeat (2) tick;
    issue_valid_i = 1'b0;
    expect_run(32'h0020F0D7, 4'd8, 32'h8, 5'd1, 1'b1);
    commit(4'd8, 1'b0);
    n = 0;
    @(negedge clk_i);
    while (!(result_valid_o && result_ready_i) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("pop_wait", n < 100, 1'b1);
    chk("no_bypass", issue_ready_o, 1'b0);
    tick;
    chk("ready_after_pop", issue_ready_o, 1'b1);
    commit(4'd9, 1'b1);
    commit(4'd10, 1'b1);
    commit(4'd11, 1'b1);
    repeat (8) tick;
    drain("drain_full");

    // issue and commit in the same cycle
    set_req(32'h0020F0D7, 4'd5, 2'b11);
    issue_valid_i = 1'b1;
    commit_valid_i = 1'b1;
    commit_i.id = 4'd5;
    commit_i.commit_kill = 1'b0;
    exp_resp.push_back(mk_resp(1'b1, 1'b1));
    expect_run(32'h0020F0D7, 4'd5, 32'h55, 5'd1, 1'b1);
    tick;
    issue_valid_i = 1'b0;
    commit_valid_i = 1'b0;
    chk("same_cycle_dispatch", ex_valid_o, 1'b1);
    drain("drain_same");

    // result held while the core stalls
    result_ready_i = 1'b0;
    issue(32'h0020F0D7, 4'd7, 2'b11, 1'b1, 1'b1);
    expect_run(32'h0020F0D7, 4'd7, 32'h77, 5'd1, 1'b1);
    commit(4'd7, 1'b0);
    n = 0;
    @(negedge clk_i);
    while (!result_valid_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("stall_wait", n < 100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", result_valid_o, 1'b1);
      chk("stall_result", result_o, mk_res(4'd7, 32'h77, 5'd1, 1'b1));
      @(negedge clk_i);
    end
    tick;
    result_ready_i = 1'b1;
    drain("drain_stall");

    // reset while waiting for completion discards the entry
    auto_done = 1'b0;
    issue(32'h0020F0D7, 4'd12, 2'b11, 1'b1, 1'b1);
    exp_ex.push_back({32'h0020F0D7, rs0_of(4'd12), rs1_of(4'd12)});
    commit(4'd12, 1'b0);
    n = 0;
    @(negedge clk_i);
    while (!(ex_valid_o && ex_ready_i) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("exec_wait", n < 100, 1'b1);
    tick;
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_issue_ready", issue_ready_o, 1'b1);
    chk("mid_rst_ex_valid", ex_valid_o, 1'b0);
    chk("mid_rst_result_valid", result_valid_o, 1'b0);
    chk("mid_rst_ex_instr", ex_instr_o, 32'h0);
    chk("mid_rst_result", result_o, '0);
    tick;
    rst_ni = 1'b1;
    repeat (10) tick;
    auto_done = 1'b1;

    // normal flow after reset
    issue(32'h0020F0D7, 4'd13, 2'b11, 1'b1, 1'b1);
    expect_run(32'h0020F0D7, 4'd13, 32'hD, 5'd1, 1'b1);
    commit(4'd13, 1'b0);
    drain("drain_post_rst");

    chk("resp_queue_empty", exp_resp.size(), 0);
    chk("ex_queue_empty", exp_ex.size(), 0);
    chk("res_queue_empty", exp_res.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
